axon_scheduler: RTL and testbench
=================================

AXON_SCHEDULER -- requirements
Module: axon_scheduler

Interface
REQ-001 SHALL have parameter: BASE_ADDR, 32'h30000000, Wishbone byte address of synapse row 0.
REQ-002 SHALL have parameter: TIMEOUT_CYC, 16, ack timeout in clocks (used only with REQ-027).
REQ-003 SHALL have ports:
- wb_clk_i  in  1  clock; all state changes on the rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  one-cycle request to process one spike frame.
- spikes_i  in  256  axon spike vector; bit k set means axon k fired.
- m_cyc_o  out  1  Wishbone cycle, master side.
- m_stb_o  out  1  Wishbone strobe.
- m_we_o  out  1  write enable; constant 0.
- m_sel_o  out  4  byte select; constant 4'b1111.
- m_adr_o  out  32  row address.
- m_ack_i  in  1  slave acknowledge.
- conn_i  in  32  row data, valid while cyc&stb&!we.
- conn_valid_o  out  1  one-cycle strobe qualifying conn_o and axon_o.
- conn_o  out  32  captured neuron-connection row.
- axon_o  out  8  index of the axon that produced conn_o.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle end-of-frame pulse.
- err_o  out  1  sticky timeout flag (REQ-027).

Function
REQ-004 SHALL implement an FSM with states IDLE, SCAN, REQ, WAIT, EMIT and DONE.
REQ-005 IDLE: on start_i=1, SHALL latch spikes_i into a 256-bit frame register, clear idx to 0, and go to SCAN.
REQ-006 SCAN SHALL test frame[idx] once per cycle:
- bit set: go to REQ.
- bit clear and idx<255: increment idx and stay in SCAN.
- bit clear and idx==255: go to DONE.
REQ-007 REQ SHALL drive m_cyc_o=m_stb_o=1 and m_adr_o=BASE_ADDR+{idx,2'b00}, then go to WAIT on the next cycle.
REQ-008 WAIT SHALL hold m_cyc_o, m_stb_o and m_adr_o stable until a rising edge that samples m_ack_i=1.
REQ-009 On that edge, SHALL register conn_o<=conn_i and axon_o<=idx, deassert m_cyc_o and m_stb_o, and go to EMIT.
REQ-010 EMIT SHALL assert conn_valid_o for exactly one cycle, then:
- idx==255: go to DONE.
- otherwise: increment idx and go to SCAN.
REQ-011 DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-012 m_cyc_o and m_stb_o SHALL be registered and high only in REQ and WAIT.
REQ-013 m_we_o SHALL be 0 and m_sel_o SHALL be 4'b1111 at all times.
REQ-014 start_i SHALL be ignored while busy_o=1.
REQ-015 Changes on spikes_i after latching SHALL NOT affect the frame in progress.
REQ-016 Spiking axons SHALL be emitted in strictly ascending index order, each exactly once per frame.
REQ-017 An all-zero frame SHALL take exactly 256 SCAN cycles, then produce the done_o pulse with no bus cycles.
REQ-018 Latency from an ack-sampling edge to conn_valid_o high SHALL be 1 cycle.
REQ-019 Address arithmetic SHALL be 32-bit modulo 2^32.
REQ-020 idx SHALL be 8 bits; 255 is terminal and idx SHALL never wrap to 0 within a frame.
REQ-021 conn_o and axon_o SHALL hold their last values between strobes.
REQ-022 m_ack_i seen outside WAIT SHALL be ignored.

Reset
REQ-023 wb_rst_i=1 SHALL immediately force the FSM to IDLE, at any state including mid-bus-cycle.
REQ-024 During reset, the following outputs SHALL be 0: m_cyc_o, m_stb_o, conn_valid_o, done_o, busy_o, err_o, conn_o, axon_o, m_adr_o.
REQ-025 During reset, idx and the frame register SHALL be 0.
REQ-026 After reset release, the block SHALL require a new start_i; the interrupted frame SHALL NOT resume.

Configuration
REQ-027 With ACK_TIMEOUT_EN defined, SHALL count cycles in WAIT. If TIMEOUT_CYC cycles pass without an ack, the block SHALL:
- deassert m_cyc_o and m_stb_o;
- set err_o=1 (cleared only by reset);
- skip EMIT for that axon and proceed as in REQ-010 without a strobe.
REQ-028 Without ACK_TIMEOUT_EN, WAIT SHALL wait indefinitely, err_o SHALL be tied to 0, and no timeout counter SHALL exist.

Verification
REQ-029 Bench SHALL cover these scenarios:
- spikes_i with bits 0, 5, 255 set; slave acks after 1 cycle -> three conn_valid_o strobes with axon_o 0, 5, 255; m_adr_o 0x30000000, 0x30000014, 0x300003FC; conn_o matches the preloaded rows; then one done_o.
- spikes_i=0 -> no m_cyc_o; done_o exactly 257 cycles after start_i.
- Second start_i while busy_o=1, with a different spikes_i -> ignored; only the first frame is emitted.
- wb_rst_i asserted in WAIT with m_cyc_o=1 -> m_cyc_o=0 and busy_o=0 asynchronously; next start_i runs a full fresh frame.
- All 256 bits set, ack delay of 3 cycles -> 256 strobes in order; m_cyc_o never overlaps EMIT.
- ACK_TIMEOUT_EN defined, slave never acks axon 7, spikes {7, 9} -> after 16 WAIT cycles err_o=1; a single strobe with axon_o=9; done_o asserted.

Source files
------------

// File: rtl/axon_scheduler.sv
// Spike-frame scheduler: walks a latched 256-bit axon frame in ascending order and fetches one
// Wishbone connection row per firing axon. Optional ack timeout enabled by `define ACK_TIMEOUT_EN.
module axon_scheduler #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         start_i,
    input  logic [255:0] spikes_i,
    output logic         m_cyc_o,
    output logic         m_stb_o,
    output logic         m_we_o,
    output logic [3:0]   m_sel_o,
    output logic [31:0]  m_adr_o,
    input  logic         m_ack_i,
    input  logic [31:0]  conn_i,
    output logic         conn_valid_o,
    output logic [31:0]  conn_o,
    output logic [7:0]   axon_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StReq,
        StWait,
        StEmit,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [255:0]   frame_q, frame_d;
    logic [7:0]     idx_q, idx_d;
    logic           cyc_q, cyc_d;
    logic [31:0]    adr_q, adr_d;
    logic [31:0]    conn_q, conn_d;
    logic [7:0]     axon_q, axon_d;
    logic           err_q, err_d;
    logic           timeout;

`ifdef ACK_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

    logic [TmoW-1:0] tmo_q, tmo_d;

    assign timeout = (tmo_q == TmoLast);
`else
    logic unused_timeout_cyc;

    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        idx_d   = idx_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        conn_d  = conn_q;
        axon_d  = axon_q;
        err_d   = err_q;
`ifdef ACK_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    frame_d = spikes_i;
                    idx_d   = 8'd0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (frame_q[idx_q]) begin
                    // Bus outputs are registered, so they are loaded on entry to REQ.
                    cyc_d   = 1'b1;
                    adr_d   = BASE_ADDR + {22'd0, idx_q, 2'b00};
                    state_d = StReq;
                end else if (idx_q == 8'd255) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            StReq: begin
`ifdef ACK_TIMEOUT_EN
                tmo_d = '0;
`endif
                state_d = StWait;
            end
            StWait: begin
                if (m_ack_i) begin
                    conn_d  = conn_i;
                    axon_d  = idx_q;
                    cyc_d   = 1'b0;
                    state_d = StEmit;
                end else if (timeout) begin
                    // Abandon this axon: no strobe, continue as EMIT would.
                    cyc_d = 1'b0;
                    err_d = 1'b1;
                    if (idx_q == 8'd255) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = StScan;
                    end
                end else begin
`ifdef ACK_TIMEOUT_EN
                    tmo_d = tmo_q + 1'b1;
`endif
                end
            end
            StEmit: begin
                if (idx_q == 8'd255) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = StScan;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            frame_q <= '0;
            idx_q   <= '0;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            conn_q  <= '0;
            axon_q  <= '0;
            err_q   <= 1'b0;
`ifdef ACK_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            conn_q  <= conn_d;
            axon_q  <= axon_d;
            err_q   <= err_d;
`ifdef ACK_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign m_cyc_o      = cyc_q;
    assign m_stb_o      = cyc_q;
    assign m_we_o       = 1'b0;
    assign m_sel_o      = 4'b1111;
    assign m_adr_o      = adr_q;
    assign conn_o       = conn_q;
    assign axon_o       = axon_q;
    assign conn_valid_o = (state_q == StEmit);
    assign done_o       = (state_q == StDone);
    assign busy_o       = (state_q != StIdle);
    assign err_o        = err_q;

endmodule

// File: tb/tb_axon_scheduler.sv
// Scoreboard bench for axon_scheduler: a Wishbone slave model serves rows, expected axons are
// queued at stimulus time and popped on each conn_valid_o strobe.
module tb_axon_scheduler;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i = 1'b0;
    logic [255:0] spikes_i = '0;
    logic         m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]   m_sel_o;
    logic [31:0]  m_adr_o;
    logic         m_ack_i = 1'b0;
    logic [31:0]  conn_i = 32'hDEAD_BEEF;
    logic         conn_valid_o;
    logic [31:0]  conn_o;
    logic [7:0]   axon_o;
    logic         busy_o, done_o, err_o;

    axon_scheduler #(
        .BASE_ADDR  (32'h3000_0000),
        .TIMEOUT_CYC(16)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .start_i     (start_i),
        .spikes_i    (spikes_i),
        .m_cyc_o     (m_cyc_o),
        .m_stb_o     (m_stb_o),
        .m_we_o      (m_we_o),
        .m_sel_o     (m_sel_o),
        .m_adr_o     (m_adr_o),
        .m_ack_i     (m_ack_i),
        .conn_i      (conn_i),
        .conn_valid_o(conn_valid_o),
        .conn_o      (conn_o),
        .axon_o      (axon_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] row_data(input logic [7:0] k);
        return {8'hC5, k, ~k, k ^ 8'h5A};
    endfunction

    // Slave model state
    int          ack_delay = 1;
    logic        ack_hold  = 1'b0;
    logic [8:0]  nack_idx  = 9'h100;
    int          cyc_run   = 0;
    int          nack_run  = 0;
    logic [7:0]  cur_idx   = '0;
    logic [31:0] last_adr  = '0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (m_cyc_o && m_stb_o) begin
                cyc_run++;
                cur_idx = m_adr_o[9:2];
                if (!ack_hold && {1'b0, cur_idx} != nack_idx && cyc_run >= ack_delay) begin
                    m_ack_i  = 1'b1;
                    conn_i   = row_data(cur_idx);
                    last_adr = m_adr_o;
                end
            end else begin
                if (cyc_run != 0 && {1'b0, cur_idx} == nack_idx) nack_run = cyc_run;
                cyc_run = 0;
                m_ack_i = 1'b0;
                conn_i  = 32'hDEAD_BEEF;
            end
        end
    end

    // Scoreboard monitor
    logic [7:0] exp_q[$];
    int         done_cnt  = 0;
    logic       cyc_seen  = 1'b0;

    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (m_cyc_o) cyc_seen = 1'b1;
            if (done_o) done_cnt++;
            if (conn_valid_o) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_strobe", {24'd0, axon_o}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("axon", {24'd0, axon_o}, {24'd0, e});
                    check_eq("conn", conn_o, row_data(e));
                    check_eq("adr", last_adr, 32'h3000_0000 + {22'd0, e, 2'b00});
                    check_eq("cyc_in_emit", {31'd0, m_cyc_o}, 32'd0);
                end
            end
        end
    end

    task automatic pulse_start(input logic [255:0] v);
        @(negedge clk);
        spikes_i = v;
        start_i  = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
        spikes_i = ~v;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq("done_seen", done_cnt - d0, 1);
        check_eq("queue_empty", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #2;
        check_eq("done_one_cycle", {31'd0, done_o}, 32'd0);
        check_eq("idle_after", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic run_frame(input logic [255:0] v, input int delay, input int budget);
        int d0 = done_cnt;
        ack_delay = delay;
        for (int k = 0; k < 256; k++)
            if (v[k] && k[8:0] != nack_idx) exp_q.push_back(k[7:0]);
        pulse_start(v);
        wait_done(d0, budget);
    endtask

    initial begin
        logic [255:0] v;
        int n;
        int d0;

        #2_000_000;
        $display("FAIL watchdog: got time-out, expected completion");
        $fatal(1);
    end

    initial begin
        logic [255:0] v;
        int n;
        int d0;

        // Reset values
        #12;
        check_eq("rst_cyc", {31'd0, m_cyc_o}, 0);
        check_eq("rst_stb", {31'd0, m_stb_o}, 0);
        check_eq("rst_busy", {31'd0, busy_o}, 0);
        check_eq("rst_done", {31'd0, done_o}, 0);
        check_eq("rst_valid", {31'd0, conn_valid_o}, 0);
        check_eq("rst_err", {31'd0, err_o}, 0);
        check_eq("rst_conn", conn_o, 0);
        check_eq("rst_axon", {24'd0, axon_o}, 0);
        check_eq("rst_adr", m_adr_o, 0);
        check_eq("rst_we", {31'd0, m_we_o}, 0);
        check_eq("rst_sel", {28'd0, m_sel_o}, 32'hF);
        @(negedge clk);
        rst = 1'b0;

        // Bits 0, 5, 255 with one-cycle ack
        v = '0;
        v[0] = 1'b1; v[5] = 1'b1; v[255] = 1'b1;
        run_frame(v, 1, 400);

        // Empty frame: done exactly 257 cycles after start, no bus traffic
        cyc_seen = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        spikes_i = '0;
        start_i  = 1'b1;
        n = 0;
        while (!done_o && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) start_i = 1'b0;
        end
        check_eq("zero_latency", n, 257);
        check_eq("zero_no_cyc", {31'd0, cyc_seen}, 0);
        @(posedge clk);
        #2;
        check_eq("zero_done_cnt", done_cnt - d0, 1);

        // Second start while busy is ignored
        v = '0;
        v[3] = 1'b1; v[100] = 1'b1;
        exp_q.push_back(8'd3);
        exp_q.push_back(8'd100);
        d0 = done_cnt;
        pulse_start(v);
        repeat (4) @(negedge clk);
        check_eq("busy_mid", {31'd0, busy_o}, 1);
        v = '0;
        v[1] = 1'b1; v[2] = 1'b1; v[50] = 1'b1;
        pulse_start(v);
        wait_done(d0, 600);
        repeat (30) @(negedge clk);
        check_eq("no_second_frame", done_cnt - d0, 1);

        // Reset during WAIT
        ack_hold = 1'b1;
        v = '0;
        v[10] = 1'b1;
        d0 = done_cnt;
        pulse_start(v);
        n = 0;
        while (!m_cyc_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_cyc_up", {31'd0, m_cyc_o}, 1);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("async_cyc", {31'd0, m_cyc_o}, 0);
        check_eq("async_busy", {31'd0, busy_o}, 0);
        check_eq("async_adr", m_adr_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ack_hold = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("no_resume_busy", {31'd0, busy_o}, 0);
        check_eq("no_resume_done", done_cnt - d0, 0);
        v = '0;
        v[10] = 1'b1; v[20] = 1'b1;
        run_frame(v, 1, 400);

        // Full frame with three-cycle ack
        run_frame({256{1'b1}}, 3, 5000);

`ifdef ACK_TIMEOUT_EN
        // Axon 7 never acked: timeout sets err and skips its strobe
        check_eq("err_before", {31'd0, err_o}, 0);
        nack_idx = 9'd7;
        v = '0;
        v[7] = 1'b1; v[9] = 1'b1;
        run_frame(v, 1, 600);
        check_eq("err_after", {31'd0, err_o}, 1);
        check_eq("tmo_cyc_len", nack_run, 17);
        nack_idx = 9'h100;
`else
        check_eq("err_tied", {31'd0, err_o}, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
